// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between instruction fetch and load/store, fixed data priority.
// Latency: 3 cycles minimum from a request sampled in IDLE to the ready pulse, +1 per memory wait cycle.
// Backpressure: requesters hold req until their one-cycle ready; stall is high while any request waits.
// Optional: define ARB_STARVE_GUARD_EN to let a waiting fetch win after STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  localparam logic [1:0] GNT_NONE  = 2'b00;
  localparam logic [1:0] GNT_FETCH = 2'b01;
  localparam logic [1:0] GNT_DATA  = 2'b10;

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_ready_q, if_ready_d;
  logic                d_ready_q, d_ready_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic [1:0]          grant_q, grant_d;
  logic                fetch_first;
  logic                take_d;
  logic                take_i;

  // Arbitration decision, only meaningful while IDLE
  always_comb begin
    take_d = 1'b0;
    take_i = 1'b0;
    if (state_q == IDLE) begin
      if (d_req && !(fetch_first && if_req)) begin
        take_d = 1'b1;
      end else if (if_req) begin
        take_i = 1'b1;
      end
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt_q, starve_cnt_d;

  assign fetch_first = (int'(starve_cnt_q) >= STARVE_LIMIT);

  // Count data grants that bypassed a waiting fetch; saturate at 7, clear when fetch wins
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (take_i) begin
      starve_cnt_d = 3'd0;
    end else if (take_d && if_req && (starve_cnt_q != 3'd7)) begin
      starve_cnt_d = starve_cnt_q + 3'd1;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_cnt_q <= 3'd0;
    else       starve_cnt_q <= starve_cnt_d;
  end
`else
  // Without the guard data always wins; the limit parameter has no effect
  logic unused_starve_limit;
  assign fetch_first         = 1'b0;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
`endif

  // Next-state and next-output logic for the access sequencer
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ready_d  = if_ready_q;
    d_ready_d   = d_ready_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    grant_d     = grant_q;
    case (state_q)
      IDLE: begin
        if (take_d) begin
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          grant_d     = GNT_DATA;
          state_d     = BUSY_D;
        end else if (take_i) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          grant_d    = GNT_FETCH;
          state_d    = BUSY_I;
        end
      end
      BUSY_I: begin
        if (mem_ack) begin
          if_rdata_d = mem_rdata;
          if_ready_d = 1'b1;
          mem_req_d  = 1'b0;
          grant_d    = GNT_NONE;
          state_d    = DONE;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          // A store returns no data, so the last load result is kept
          if (!mem_we_q) d_rdata_d = mem_rdata;
          d_ready_d = 1'b1;
          mem_req_d = 1'b0;
          grant_d   = GNT_NONE;
          state_d   = DONE;
        end
      end
      DONE: begin
        // The finished requester still shows its request here, so nothing is sampled
        if_ready_d = 1'b0;
        d_ready_d  = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs, cleared immediately on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      grant_q     <= GNT_NONE;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      grant_q     <= grant_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ready  = if_ready_q;
  assign d_ready   = d_ready_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign grant     = grant_q;
  assign stall     = (if_req & ~if_ready_q) | (d_req & ~d_ready_q);

endmodule
